// File: rtl/m68k_bus_responder_pkg.sv
// ---------------------------------------------------------------------------
// m68k_bus_responder_pkg
// Shared definitions for the 68000 bus responder: FSM state encoding,
// default address window and timeout, and the window-decode helper.
// ---------------------------------------------------------------------------
package m68k_bus_responder_pkg;

  typedef enum logic [3:0] {
    RSP_IDLE,
    RSP_DECODE,
    RSP_IGNORE,
    RSP_WAIT_DS,
    RSP_REQUEST,
    RSP_WAIT_RSP,
    RSP_ACK,
    RSP_ERROR,
    RSP_RELEASE,
    RSP_DRAIN
  } rsp_state_t;

  localparam logic [23:0] DEFAULT_BASE_ADDR = 24'hE9_0000;
  localparam logic [23:0] DEFAULT_ADDR_MASK = 24'hFF_0000;
  localparam int          DEFAULT_TIMEOUT   = 255;

  // Byte address hit test; bit 0 never takes part (68000 has no A0).
  function automatic logic addr_in_window(input logic [23:0] addr,
                                          input logic [23:0] base,
                                          input logic [23:0] mask);
    return ((addr ^ base) & mask & 24'hFF_FFFE) == 24'h0;
  endfunction

endpackage

// File: rtl/m68k_bus_responder_strobe_sync.sv
// ---------------------------------------------------------------------------
// m68k_bus_responder_strobe_sync
// Plain 2-flop synchroniser for asynchronous bus control lines.
//   sys_clk   in   destination clock
//   rst       in   asynchronous, active-high reset
//   async_in  in   WIDTH asynchronous inputs
//   sync_out  out  WIDTH synchronised outputs (reset to RESET_VAL)
// RESET_VAL lets active-low strobes come out of reset in their idle state.
// ---------------------------------------------------------------------------
module m68k_bus_responder_strobe_sync #(
  parameter int                 WIDTH     = 4,
  parameter logic [WIDTH-1:0]   RESET_VAL = '1
) (
  input  logic             sys_clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] async_in,
  output logic [WIDTH-1:0] sync_out
);

  logic [WIDTH-1:0] meta_q;

  // NOTE: non-blocking assignments make both flops sample the old value of
  // their source on the same edge, which is what builds a two-stage chain.
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      meta_q   <= RESET_VAL;
      sync_out <= RESET_VAL;
    end else begin
      meta_q   <= async_in;
      sync_out <= meta_q;
    end
  end

endmodule

// File: rtl/m68k_bus_responder.sv
// ---------------------------------------------------------------------------
// m68k_bus_responder
// 68000 bus target: decodes an address window on a bus driven by another
// master, forwards each hit cycle as one local request, and terminates the
// bus cycle with nDTACK (response) or nBERR (local timeout).
//   SYSCLK, RESET            clock, asynchronous active-high reset
//   MASTER_ACTIVE            PiStorm owns the bus; new cycles are ignored
//   AS_N/UDS_N/LDS_N/RNW     asynchronous 68000 control lines
//   A_IN, D_IN               address A[23:1] and data, sampled once stable
//   D_OUT, D_OE              read data and its bus drive enable
//   DTACK_OE, BERR_OE        open-drain pull-down enables
//   REQ_*                    local request, valid/ready handshake
//   RSP_VALID, RSP_RDATA     single-cycle local response
//   BUSY                     FSM not idle
// ---------------------------------------------------------------------------
module m68k_bus_responder
  import m68k_bus_responder_pkg::*;
#(
  parameter logic [23:0] BASE_ADDR = DEFAULT_BASE_ADDR,
  parameter logic [23:0] ADDR_MASK = DEFAULT_ADDR_MASK,
  parameter int          TIMEOUT   = DEFAULT_TIMEOUT
) (
  input  logic        SYSCLK,
  input  logic        RESET,
  input  logic        MASTER_ACTIVE,
  input  logic        AS_N,
  input  logic        UDS_N,
  input  logic        LDS_N,
  input  logic        RNW,
  input  logic [23:1] A_IN,
  input  logic [15:0] D_IN,
  output logic [15:0] D_OUT,
  output logic        D_OE,
  output logic        DTACK_OE,
  output logic        BERR_OE,
  output logic        REQ_VALID,
  input  logic        REQ_READY,
  output logic [23:0] REQ_ADDR,
  output logic [1:0]  REQ_BE,
  output logic        REQ_READ,
  output logic [15:0] REQ_WDATA,
  input  logic        RSP_VALID,
  input  logic [15:0] RSP_RDATA,
  output logic        BUSY
);

  localparam int              CNT_W    = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT);

  // Synchronised strobes, converted to active-high.
  logic as_n_s, uds_n_s, lds_n_s, rnw_s;
  logic as, uds, lds;

  m68k_bus_responder_strobe_sync #(
    .WIDTH     (4),
    .RESET_VAL (4'b1111)
  ) u_strobe_sync (
    .sys_clk  (SYSCLK),
    .rst      (RESET),
    .async_in ({AS_N, UDS_N, LDS_N, RNW}),
    .sync_out ({as_n_s, uds_n_s, lds_n_s, rnw_s})
  );

  assign as  = ~as_n_s;
  assign uds = ~uds_n_s;
  assign lds = ~lds_n_s;

  rsp_state_t       state_q, state_d;
  logic [23:1]      addr_q;
  logic             read_q;
  logic [1:0]       be_q;
  logic [15:0]      wdata_q;
  logic [15:0]      rdata_q;
  logic [CNT_W-1:0] cnt_q, cnt_next;
  logic             timeout_hit;
  logic             ld_addr, ld_be, ld_rdata, cnt_clr, cnt_inc;
  logic             dtack_q, doe_q, berr_q;

  // Saturating count; once at CNT_LAST the timeout condition stays true.
  assign cnt_next    = (cnt_q == CNT_LAST) ? cnt_q : cnt_q + 1'b1;
  assign timeout_hit = (cnt_next == CNT_LAST);

  // NOTE: every signal assigned here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d  = state_q;
    ld_addr  = 1'b0;
    ld_be    = 1'b0;
    ld_rdata = 1'b0;
    cnt_clr  = 1'b0;
    cnt_inc  = 1'b0;
    case (state_q)
      RSP_IDLE: begin
        if (as && !MASTER_ACTIVE) begin
          ld_addr = 1'b1;
          state_d = RSP_DECODE;
        end
      end
      RSP_DECODE:
        state_d = addr_in_window({addr_q, 1'b0}, BASE_ADDR, ADDR_MASK) ? RSP_WAIT_DS
                                                                      : RSP_IGNORE;
      RSP_IGNORE:
        if (!as) state_d = RSP_IDLE;
      RSP_WAIT_DS: begin
        if (!as) begin
          state_d = RSP_IDLE;
        end else if (uds || lds) begin
          ld_be   = 1'b1;
          state_d = RSP_REQUEST;
        end
      end
      RSP_REQUEST: begin
        // An offered request that is accepted is committed even if AS
        // drops in the same cycle; the response is then drained.
        if (REQ_READY) begin
          cnt_clr = 1'b1;
          state_d = RSP_WAIT_RSP;
        end else if (!as) begin
          state_d = RSP_IDLE;
        end
      end
      RSP_WAIT_RSP: begin
        cnt_inc = 1'b1;
        if (RSP_VALID) begin
          ld_rdata = read_q;
          state_d  = as ? RSP_ACK : RSP_IDLE;
        end else if (!as) begin
          state_d = RSP_DRAIN;
        end else if (timeout_hit) begin
          state_d = RSP_ERROR;
        end
      end
      RSP_ACK:
        if (!as) state_d = RSP_RELEASE;
      RSP_ERROR:
        if (!as) state_d = RSP_RELEASE;
      RSP_RELEASE:
        state_d = RSP_IDLE;
      RSP_DRAIN: begin
        cnt_inc = 1'b1;
        if (RSP_VALID || timeout_hit) state_d = RSP_IDLE;
      end
      default:
        state_d = RSP_IDLE;
    endcase
  end

  always_ff @(posedge SYSCLK or posedge RESET) begin
    if (RESET) begin
      state_q <= RSP_IDLE;
      addr_q  <= '0;
      read_q  <= 1'b0;
      be_q    <= 2'b00;
      wdata_q <= '0;
      rdata_q <= '0;
      cnt_q   <= '0;
      dtack_q <= 1'b0;
      doe_q   <= 1'b0;
      berr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (ld_addr) begin
        addr_q <= A_IN;
        read_q <= rnw_s;
      end
      // Data strobes follow valid write data, so D_IN is settled here.
      if (ld_be) begin
        be_q <= {uds, lds};
        if (!read_q) wdata_q <= D_IN;
      end
      if (ld_rdata) rdata_q <= RSP_RDATA;
      if (cnt_clr)      cnt_q <= '0;
      else if (cnt_inc) cnt_q <= cnt_next;
      // Pin enables are registered from the next state so the open-drain
      // lines never see decode glitches; timing equals decoding state_q.
      dtack_q <= (state_d == RSP_ACK);
      doe_q   <= (state_d == RSP_ACK) && read_q;
      berr_q  <= (state_d == RSP_ERROR);
    end
  end

  assign D_OUT     = rdata_q;
  assign D_OE      = doe_q;
  assign DTACK_OE  = dtack_q;
  assign BERR_OE   = berr_q;
  assign REQ_VALID = (state_q == RSP_REQUEST);
  assign REQ_ADDR  = {addr_q, 1'b0};
  assign REQ_BE    = be_q;
  assign REQ_READ  = read_q;
  assign REQ_WDATA = wdata_q;
  assign BUSY      = (state_q != RSP_IDLE);

endmodule

// File: tb/tb_m68k_bus_responder.sv
// ---------------------------------------------------------------------------
// tb_m68k_bus_responder
// Self-checking bench: a bus-master task drives 68000 cycles, a local-side
// process accepts requests and returns responses, and every outcome is
// compared with what the window/timeout rules predict for that cycle.
// ---------------------------------------------------------------------------
module tb_m68k_bus_responder;

  localparam logic [23:0] BASE    = 24'hE9_0000;
  localparam logic [23:0] MASK    = 24'hFF_0000;
  localparam int          TIMEOUT = 255;

  logic        SYSCLK = 1'b0;
  logic        RESET;
  logic        MASTER_ACTIVE;
  logic        AS_N, UDS_N, LDS_N, RNW;
  logic [23:1] A_IN;
  logic [15:0] D_IN;
  logic [15:0] D_OUT;
  logic        D_OE, DTACK_OE, BERR_OE;
  logic        REQ_VALID, REQ_READY;
  logic [23:0] REQ_ADDR;
  logic [1:0]  REQ_BE;
  logic        REQ_READ;
  logic [15:0] REQ_WDATA;
  logic        RSP_VALID;
  logic [15:0] RSP_RDATA;
  logic        BUSY;

  m68k_bus_responder #(
    .BASE_ADDR (BASE),
    .ADDR_MASK (MASK),
    .TIMEOUT   (TIMEOUT)
  ) dut (
    .SYSCLK        (SYSCLK),
    .RESET         (RESET),
    .MASTER_ACTIVE (MASTER_ACTIVE),
    .AS_N          (AS_N),
    .UDS_N         (UDS_N),
    .LDS_N         (LDS_N),
    .RNW           (RNW),
    .A_IN          (A_IN),
    .D_IN          (D_IN),
    .D_OUT         (D_OUT),
    .D_OE          (D_OE),
    .DTACK_OE      (DTACK_OE),
    .BERR_OE       (BERR_OE),
    .REQ_VALID     (REQ_VALID),
    .REQ_READY     (REQ_READY),
    .REQ_ADDR      (REQ_ADDR),
    .REQ_BE        (REQ_BE),
    .REQ_READ      (REQ_READ),
    .REQ_WDATA     (REQ_WDATA),
    .RSP_VALID     (RSP_VALID),
    .RSP_RDATA     (RSP_RDATA),
    .BUSY          (BUSY)
  );

  always #5 SYSCLK = ~SYSCLK;

  int unsigned cyc = 0;
  always @(posedge SYSCLK) cyc <= cyc + 1;

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct {
    logic [23:0] addr;
    logic [1:0]  be;
    logic        rd;
    logic [15:0] wdata;
    int unsigned acc_cyc;
  } req_t;

  req_t acc_q[$];

  // Local-side behaviour knobs, set by the bus-master task per cycle.
  int          ready_dly = 0;
  int          rsp_dly   = 0;
  logic [15:0] rsp_data  = 16'h0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Window rule: address bits selected by MASK (A0 excluded) equal BASE's.
  function automatic bit in_window(input logic [23:0] a);
    logic [23:0] m;
    m = MASK & 24'hFF_FFFE;
    return (a & m) == (BASE & m);
  endfunction

  // Local side: accepts each offered request after ready_dly cycles and
  // answers rsp_dly cycles after acceptance (never, if rsp_dly < 0).
  initial begin : local_side
    req_t r;
    bit   gone;
    REQ_READY = 1'b0;
    RSP_VALID = 1'b0;
    RSP_RDATA = 16'h0;
    forever begin
      @(negedge SYSCLK);
      if (REQ_VALID === 1'b1) begin
        gone = 1'b0;
        for (int i = 0; i < ready_dly && !gone; i++) begin
          @(negedge SYSCLK);
          if (REQ_VALID !== 1'b1) gone = 1'b1;
        end
        if (!gone) begin
          REQ_READY = 1'b1;
          r.addr    = REQ_ADDR;
          r.be      = REQ_BE;
          r.rd      = REQ_READ;
          r.wdata   = REQ_WDATA;
          r.acc_cyc = cyc + 1;
          acc_q.push_back(r);
          @(negedge SYSCLK);
          REQ_READY = 1'b0;
          if (rsp_dly >= 0) begin
            repeat (rsp_dly) @(negedge SYSCLK);
            RSP_VALID = 1'b1;
            RSP_RDATA = rsp_data;
            @(negedge SYSCLK);
            RSP_VALID = 1'b0;
            RSP_RDATA = 16'($urandom);
          end
        end
      end
    end
  end

  // One complete bus cycle. be is active-high {UDS,LDS}. abort_after >= 0
  // negates the strobes that many cycles after the request is accepted.
  task automatic do_cycle(input string tag, input logic [23:0] addr, input bit rd,
                          input logic [1:0] be, input logic [15:0] wd,
                          input logic [15:0] rdat, input int rdly, input int rsp_d,
                          input int abort_after);
    bit          hit, exp_ack, exp_berr;
    bit          saw_dtack, saw_berr, saw_doe, saw_busy, overlap, done;
    logic [15:0] dout_ack;
    int unsigned berr_cyc;
    int          hold, post_hi, qn, i_rel, k;
    logic        busy_tr [14];
    req_t        r;

    hit      = !MASTER_ACTIVE && in_window(addr);
    exp_ack  = hit && rsp_d >= 0 && abort_after < 0;
    exp_berr = hit && rsp_d < 0 && abort_after < 0;
    {saw_dtack, saw_berr, saw_doe, saw_busy, overlap, done} = '0;
    dout_ack = 16'h0;
    berr_cyc = 0;
    hold     = 0;
    post_hi  = 0;
    i_rel    = -1;
    foreach (busy_tr[j]) busy_tr[j] = 1'bx;
    ready_dly = rdly;
    rsp_dly   = rsp_d;
    rsp_data  = rdat;
    qn        = acc_q.size();

    @(negedge SYSCLK);
    A_IN = addr[23:1];
    RNW  = rd;
    D_IN = rd ? 16'($urandom) : wd;
    AS_N = 1'b0;
    if (rd) {UDS_N, LDS_N} = ~be;
    @(negedge SYSCLK);
    {UDS_N, LDS_N} = ~be;

    for (int i = 0; i < TIMEOUT + 60; i++) begin
      @(negedge SYSCLK);
      if (DTACK_OE === 1'b1 && !saw_dtack) dout_ack = D_OUT;
      if (DTACK_OE === 1'b1) saw_dtack = 1'b1;
      if (D_OE === 1'b1) saw_doe = 1'b1;
      if (BUSY === 1'b1) saw_busy = 1'b1;
      if (BERR_OE === 1'b1 && (DTACK_OE !== 1'b0 || D_OE !== 1'b0)) overlap = 1'b1;
      if (BERR_OE === 1'b1 && !saw_berr) begin
        saw_berr = 1'b1;
        berr_cyc = cyc;
      end
      if (i_rel < 0) begin
        if (DTACK_OE === 1'b1 || BERR_OE === 1'b1) hold++;
        if (abort_after < 0)
          done = (hold == 3) || (!hit && i >= 10);
        else
          done = (acc_q.size() > qn) && (cyc >= acc_q[qn].acc_cyc + abort_after);
        if (done) begin
          AS_N  = 1'b1;
          UDS_N = 1'b1;
          LDS_N = 1'b1;
          i_rel = i;
        end
      end else begin
        k = i - i_rel - 1;
        if (DTACK_OE === 1'b1 || BERR_OE === 1'b1) post_hi++;
        busy_tr[k] = BUSY;
        if (k == 13) break;
      end
    end
    if (i_rel < 0) begin
      AS_N  = 1'b1;
      UDS_N = 1'b1;
      LDS_N = 1'b1;
    end

    check({tag, ":done"}, 32'(i_rel >= 0), 32'd1);
    check({tag, ":nreq"}, acc_q.size() - qn, hit ? 1 : 0);
    if (hit && acc_q.size() > qn) begin
      r = acc_q[qn];
      check({tag, ":addr"}, r.addr, {addr[23:1], 1'b0});
      check({tag, ":be"}, r.be, be);
      check({tag, ":read"}, r.rd, rd);
      if (!rd) check({tag, ":wdata"}, r.wdata, wd);
      if (exp_berr) check({tag, ":berr_lat"}, berr_cyc - r.acc_cyc, TIMEOUT);
    end
    check({tag, ":dtack"}, saw_dtack, exp_ack);
    check({tag, ":berr"}, saw_berr, exp_berr);
    check({tag, ":oe_excl"}, overlap, 1'b0);
    if (exp_ack) begin
      check({tag, ":d_oe"}, saw_doe, rd);
      if (rd) check({tag, ":d_out"}, dout_ack, rdat);
    end
    if (exp_ack || exp_berr) begin
      check({tag, ":hold"}, post_hi, 2);
      check({tag, ":release"}, busy_tr[2], 1'b1);
      check({tag, ":idle_after"}, busy_tr[3], 1'b0);
    end
    if (MASTER_ACTIVE) check({tag, ":stay_idle"}, saw_busy, 1'b0);
    check({tag, ":end_idle"}, busy_tr[13], 1'b0);
  endtask

  initial begin : main
    logic [23:0] ra;
    bit          rrd, got;
    logic [1:0]  rbe;

    RESET         = 1'b1;
    MASTER_ACTIVE = 1'b0;
    AS_N          = 1'b1;
    UDS_N         = 1'b1;
    LDS_N         = 1'b1;
    RNW           = 1'b1;
    A_IN          = '0;
    D_IN          = 16'h0;
    repeat (3) @(negedge SYSCLK);
    check("reset:oes", {D_OE, DTACK_OE, BERR_OE, REQ_VALID, BUSY}, 5'b0);
    check("reset:req", {REQ_ADDR, REQ_BE, REQ_READ}, 27'h0);
    check("reset:data", {D_OUT, REQ_WDATA}, 32'h0);
    RESET = 1'b0;
    repeat (2) @(negedge SYSCLK);

    // Word read, immediate accept, response 3 cycles later.
    do_cycle("word_rd", 24'hE9_0010, 1'b1, 2'b11, 16'h0, 16'hBEEF, 0, 3, -1);
    // Byte write on the odd byte (LDS only).
    do_cycle("byte_wr", 24'hE9_0003, 1'b0, 2'b01, 16'h0055, 16'h0, 1, 2, -1);
    // Outside the window, then a normal hit.
    do_cycle("miss", 24'hBF_E001, 1'b1, 2'b01, 16'h0, 16'h1111, 0, 1, -1);
    do_cycle("after_miss", 24'hE9_FFFE, 1'b1, 2'b10, 16'h0, 16'hC0DE, 2, 0, -1);
    // No response: bus error after the timeout.
    do_cycle("timeout", 24'hE9_0100, 1'b1, 2'b11, 16'h0, 16'h0, 0, -1, -1);
    // Master gives up while waiting; late response must be discarded.
    do_cycle("abort", 24'hE9_0020, 1'b1, 2'b11, 16'h0, 16'h1234, 0, 8, 2);
    do_cycle("after_abort", 24'hE9_0022, 1'b1, 2'b11, 16'h0, 16'h5678, 0, 2, -1);
    // PiStorm owns the bus: a hit address is ignored.
    MASTER_ACTIVE = 1'b1;
    do_cycle("master_act", 24'hE9_0040, 1'b1, 2'b11, 16'h0, 16'h2222, 0, 1, -1);
    MASTER_ACTIVE = 1'b0;

    // Randomised cycles mixing hits and misses, reads and writes.
    for (int n = 0; n < 16; n++) begin
      if ($urandom_range(0, 3) != 0) ra = BASE | 24'($urandom_range(0, 16'hFFFF));
      else                           ra = 24'($urandom);
      rrd = 1'($urandom_range(0, 1));
      rbe = 2'($urandom_range(1, 3));
      do_cycle($sformatf("rnd%0d", n), ra, rrd, rbe, 16'($urandom), 16'($urandom),
               $urandom_range(0, 3), $urandom_range(0, 6), -1);
    end

    // Reset while acknowledging: enables must drop at once.
    ready_dly = 0;
    rsp_dly   = 1;
    rsp_data  = 16'hA5A5;
    @(negedge SYSCLK);
    A_IN  = 23'h748020;
    RNW   = 1'b1;
    AS_N  = 1'b0;
    UDS_N = 1'b0;
    LDS_N = 1'b0;
    got   = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge SYSCLK);
      got = (DTACK_OE === 1'b1);
    end
    check("rst_ack:reached", got, 1'b1);
    #1 RESET = 1'b1;
    #1;
    check("rst_ack:dtack", DTACK_OE, 1'b0);
    check("rst_ack:d_oe", D_OE, 1'b0);
    check("rst_ack:busy_dout", {BUSY, D_OUT}, 17'h0);
    AS_N  = 1'b1;
    UDS_N = 1'b1;
    LDS_N = 1'b1;
    repeat (3) @(negedge SYSCLK);
    RESET = 1'b0;
    repeat (2) @(negedge SYSCLK);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/m68k_bus_responder.md
Name: m68k_bus_responder

Overview:
- 68000 bus target (responder) for the Amiga side of PiStorm16: watches nAS/nUDS/nLDS/RnW/A driven by another bus master.
- Decodes a parameterised address window and forwards each hit cycle to a local request/response port, serviced by Pi-side logic.
- Drives nDTACK (open-drain) and, on reads, D; terminates with nBERR on local timeout.
- Counterpart to the existing bus-master state machine. Inhibited whenever the PiStorm is bus master.

Parameters:
- BASE_ADDR, 24'hE90000, window base (byte address, bit 0 ignored)
- ADDR_MASK, 24'hFF0000, address bits compared against BASE_ADDR
- TIMEOUT, 255, sys-clock cycles allowed between request issue and response before BERR

Ports:
- SYSCLK  in  1  system clock (PLL)
- RESET  in  1  asynchronous, active-high reset
- MASTER_ACTIVE  in  1  PiStorm owns bus; block stays idle
- AS_N  in  1  address strobe, async
- UDS_N  in  1  upper data strobe, async
- LDS_N  in  1  lower data strobe, async
- RNW  in  1  read/write, async
- A_IN  in  23  address A[23:1], async
- D_IN  in  16  data bus input
- D_OUT  out  16  read data
- D_OE  out  1  drive D
- DTACK_OE  out  1  pull nDTACK low
- BERR_OE  out  1  pull nBERR low
- REQ_VALID  out  1  local request pending
- REQ_READY  in  1  local side accepts request
- REQ_ADDR  out  24  byte address, bit0=0
- REQ_BE  out  2  {UDS,LDS} active-high byte enables
- REQ_READ  out  1  1=read
- REQ_WDATA  out  16  write data
- RSP_VALID  in  1  response strobe (1 cycle)
- RSP_RDATA  in  16  read data
- BUSY  out  1  state != IDLE

Behaviour:
- Reset (async): all outputs 0, state IDLE, timeout counter 0.
- AS_N, UDS_N, LDS_N, RNW: 2-FF synchronisers. A_IN/D_IN sampled only after synchronised strobe is seen, so they are stable.
- States and transitions:
  - IDLE: on as=1 & !MASTER_ACTIVE, latch A_IN/RNW, go DECODE.
  - DECODE: ((addr ^ BASE_ADDR) & ADDR_MASK) == 0 → WAIT_DS; otherwise → IGNORE.
  - IGNORE: stay until as=0 → IDLE. No outputs asserted.
  - WAIT_DS: when any ds=1, latch REQ_BE = {~UDS,~LDS}. On writes also latch D_IN into REQ_WDATA (valid because DS follows data on writes). Go REQUEST.
  - REQUEST: REQ_VALID=1 and held until REQ_READY. Fields stay stable while REQ_VALID=1. On accept → WAIT_RSP, counter cleared.
  - WAIT_RSP: on RSP_VALID, latch RSP_RDATA into D_OUT (reads) → ACK. Counter increments; when counter == TIMEOUT → ERROR.
  - ACK: DTACK_OE=1; D_OE=REQ_READ. Held until as=0 → RELEASE.
  - ERROR: BERR_OE=1 until as=0 → RELEASE. D_OE=0.
  - RELEASE: one cycle with all OEs 0 (bus hand-back), → IDLE.
- Latency: DTACK_OE asserts one sys cycle after RSP_VALID. D_OE asserts in that same cycle, with D_OUT already stable.
- Abort: as=0 in WAIT_DS or REQUEST → IDLE; REQ_VALID drops, which is allowed only before acceptance.
- Abort in WAIT_RSP → DRAIN: wait for RSP_VALID or timeout, discard the response, → IDLE. A stale response is never presented to the next cycle.
- RSP_VALID outside WAIT_RSP/DRAIN is ignored.
- MASTER_ACTIVE rising mid-cycle has no effect on the cycle in progress; it is checked only in IDLE.
- REQ_ADDR = {latched A, 1'b0}. Word and byte accesses are both single requests.
- Counter is 8 bits wide (ceil log2(TIMEOUT+1)) and saturates; never wraps.
- D_OE and DTACK_OE are never 1 simultaneously with BERR_OE.

Decomposition:
- Shared package (global.vh): state encodings RSP_IDLE..RSP_DRAIN, default BASE/MASK constants.
- One sub-module, strobe_sync: 2-FF synchroniser, 4 bits wide, for AS/UDS/LDS/RNW. Reusable elsewhere.

Test Plan:
- Word read at 0xE90010, REQ_READY=1 immediately, RSP_VALID 3 cycles later with 0xBEEF → REQ_ADDR=0xE90010, BE=2'b11, READ=1; D_OUT=0xBEEF with D_OE and DTACK_OE until AS_N=1; one RELEASE cycle; then IDLE.
- Byte write of 0x0055 at odd address 0xE90003 (LDS only) → REQ_BE=2'b01, REQ_WDATA=0x0055, REQ_READ=0; DTACK_OE=1 and D_OE stays 0 throughout.
- Access at 0xBFE001 (miss) → no REQ_VALID, no OE for the whole cycle; next hit cycle is serviced normally.
- No RSP_VALID, TIMEOUT=255 → BERR_OE asserts exactly 255 cycles after acceptance and is held until AS_N=1; DTACK_OE never asserts.
- AS_N negated 2 cycles after acceptance, RSP_VALID 0x1234 arrives later → response discarded, no DTACK; next read returns its own data, not 0x1234.
- MASTER_ACTIVE=1 with a hit address → block stays IDLE; RESET asserted during ACK → DTACK_OE and D_OE drop immediately (async).
